rf_scoreboard: RTL and testbench

Parametrised successor of the core integer register file.
- Generalised in data width, address width and read-port count.
- Adds register 0 hardwired to zero, asynchronous clear and a per-register busy scoreboard.
- The scoreboard tracks in-flight producers so the issue stage can detect RAW hazards.
- Sits between decode/issue (read and issue ports) and writeback (write port).

---
 rtl/rf_scoreboard.sv | 166 ++++++++++++++++
 tb/tb_rf_scoreboard.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
//
// Parametrised integer register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never busy. The issue stage marks a
// destination as in-flight; the writeback write to that register retires it.
// Read ports report both the register value and whether a producer is still
// pending on the source, so issue logic can detect RAW hazards.
//
// Optional build macro: RF_BYPASS_EN
//   defined   : same-cycle write-to-read forwarding on every read port
//   undefined : reads see the pre-edge register value only
//
// Parameters
//   ADDR_WIDTH  register index width, depth = 2**ADDR_WIDTH
//   DATA_WIDTH  register data width
//   NR_RD       number of read ports (1..4)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset (clears registers and scoreboard)
//   wen        writeback write enable
//   waddr      writeback destination index
//   wdata      writeback data
//   rs         read indices, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata      read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rbusy      per-port flag: source register has a pending producer
//   iss_valid  issue stage marks iss_rd as in-flight
//   iss_rd     destination index being issued
//   busy_cnt   number of registers currently busy
//   dbg_rf     flat snapshot of all registers, reg i at [i*DATA_WIDTH +: ...]
// -----------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RD      = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wen,
  input  logic [ADDR_WIDTH-1:0]               waddr,
  input  logic [DATA_WIDTH-1:0]               wdata,
  input  logic [NR_RD*ADDR_WIDTH-1:0]         rs,
  output logic [NR_RD*DATA_WIDTH-1:0]         rdata,
  output logic [NR_RD-1:0]                    rbusy,
  input  logic                                iss_valid,
  input  logic [ADDR_WIDTH-1:0]               iss_rd,
  output logic [ADDR_WIDTH:0]                 busy_cnt,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] dbg_rf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // Register storage. Asynchronous clear of every entry rules out block RAM,
  // so this is a flop array. Entry 0 is never written and stays 0.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic                  w_wr_en;

  assign w_wr_en = wen && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_rf[waddr] <= wdata;
    end
  end

  // Architectural view of the file with entry 0 forced to zero; shared by the
  // read ports and the debug snapshot.
  logic [DATA_WIDTH-1:0] w_rf_view [DEPTH];

  assign w_rf_view[0] = '0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_view
      assign w_rf_view[gi] = r_rf[gi];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dbg
      assign dbg_rf[gi*DATA_WIDTH +: DATA_WIDTH] = w_rf_view[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Set (new producer issued) takes priority over clear
  // (writeback retiring the old producer) on the same register, because the
  // newer producer is the one the consumers must wait for.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;

  assign w_set[0]       = 1'b0;
  assign w_clr[0]       = 1'b0;
  assign w_busy_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_busy
      localparam logic [ADDR_WIDTH-1:0] LP_IDX = ADDR_WIDTH'(gi);

      assign w_set[gi]       = iss_valid && (iss_rd == LP_IDX);
      assign w_clr[gi]       = wen && (waddr == LP_IDX);
      assign w_busy_next[gi] = w_set[gi] ? 1'b1 : (w_clr[gi] ? 1'b0 : r_busy[gi]);
    end
  endgenerate

  // At most one register can rise (single issue port) and at most one can
  // fall (single write port) per edge, so the count moves by -1, 0 or +1.
  logic w_rise;
  logic w_fall;
  logic [ADDR_WIDTH:0] r_busy_cnt;

  assign w_rise = |(w_busy_next & ~r_busy);
  assign w_fall = |(~w_busy_next & r_busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= r_busy_cnt + {{ADDR_WIDTH{1'b0}}, w_rise}
                               - {{ADDR_WIDTH{1'b0}}, w_fall};
    end
  end

  assign busy_cnt = r_busy_cnt;

  // ---------------------------------------------------------------------------
  // Read ports. Combinational, zero latency.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NR_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_rs;
      logic [DATA_WIDTH-1:0] w_val;
      logic                  w_bsy;

      assign w_rs = rs[gi*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef RF_BYPASS_EN
      // Forward the writeback value in the same cycle. The register only
      // stays busy if this very edge re-issues it to a new producer.
      logic w_fwd;

      assign w_fwd = w_wr_en && (waddr == w_rs);
      assign w_val = w_fwd ? wdata : w_rf_view[w_rs];
      assign w_bsy = w_fwd ? (iss_valid && (iss_rd == w_rs)) : r_busy[w_rs];
`else
      assign w_val = w_rf_view[w_rs];
      assign w_bsy = r_busy[w_rs];
`endif

      assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_val;
      assign rbusy[gi]                          = w_bsy;
    end
  endgenerate

endmodule

// File: tb/tb_rf_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_rf_scoreboard
//
// Directed testbench for rf_scoreboard (default parameters). Inputs change
// 1 time unit after the rising edge; outputs are sampled a further unit later,
// well away from the next edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rf_scoreboard;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   wen;
  logic [AW-1:0]          waddr;
  logic [DW-1:0]          wdata;
  logic [NR*AW-1:0]       rs;
  logic [NR*DW-1:0]       rdata;
  logic [NR-1:0]          rbusy;
  logic                   iss_valid;
  logic [AW-1:0]          iss_rd;
  logic [AW:0]            busy_cnt;
  logic [(2**AW)*DW-1:0]  dbg_rf;

  int n_vec;
  int n_miss;

  rf_scoreboard #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NR_RD      (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .rs        (rs),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy_cnt  (busy_cnt),
    .dbg_rf    (dbg_rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen       = 1'b0;
    waddr     = '0;
    wdata     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    rs        = '0;
  endtask

  function automatic logic [DW-1:0] rd_port(input int k);
    return rdata[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] dbg_reg(input int i);
    return dbg_rf[i*DW +: DW];
  endfunction

  initial begin
    n_vec  = 0;
    n_miss = 0;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("por_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("por_dbg_rf_or", 64'(|dbg_rf), 64'd0);
    #2 rst_n = 1'b1;

    // 1. write reg5 and make it busy, then reset mid-cycle
    tick();
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    idle();
    rs[0 +: AW] = 5'd5;
    #1;
    chk("t1_pre_rdata", 64'(rd_port(0)), 64'hDEADBEEF);
    chk("t1_pre_cnt", 64'(busy_cnt), 64'd1);
    chk("t1_pre_rbusy", 64'(rbusy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_rdata", 64'(rd_port(0)), 64'd0);
    chk("t1_rst_cnt", 64'(busy_cnt), 64'd0);
    chk("t1_rst_rbusy", 64'(rbusy[0]), 64'd0);
    // pending write and issue while reset is held must be discarded
    wen = 1'b1; waddr = 5'd8; wdata = 32'h55;
    iss_valid = 1'b1; iss_rd = 5'd8;
    tick();
    chk("t1_rst_drop_w", 64'(dbg_reg(8)), 64'd0);
    chk("t1_rst_drop_cnt", 64'(busy_cnt), 64'd0);
    idle();
    #2 rst_n = 1'b1;

    // 2. register 0 handling
    tick();
    wen = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    tick();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    idle();
    #1;
    chk("t2_r0_rdata", 64'(rd_port(0)), 64'd0);
    chk("t2_r0_rbusy", 64'(rbusy[0]), 64'd0);
    chk("t2_r0_cnt", 64'(busy_cnt), 64'd0);
    chk("t2_r0_dbg", 64'(dbg_reg(0)), 64'd0);

    // 3. basic write/read across two ports
    wen = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    tick();
    waddr = 5'd7; wdata = 32'h0000FFFF;
    tick();
    idle();
    rs = {5'd3, 5'd7};
    #1;
    chk("t3_port0", 64'(rd_port(0)), 64'h0000FFFF);
    chk("t3_port1", 64'(rd_port(1)), 64'hA5A5A5A5);
    chk("t3_dbg3", 64'(dbg_reg(3)), 64'hA5A5A5A5);

    // 4. scoreboard lifecycle on reg4
    tick();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    idle();
    rs[0 +: AW] = 5'd4;
    #1;
    chk("t4_iss_cnt", 64'(busy_cnt), 64'd1);
    chk("t4_iss_rbusy", 64'(rbusy[0]), 64'd1);
    wen = 1'b1; waddr = 5'd4; wdata = 32'h11;
    #1;
`ifdef RF_BYPASS_EN
    chk("t4_wb_same_rbusy", 64'(rbusy[0]), 64'd0);
    chk("t4_wb_same_rdata", 64'(rd_port(0)), 64'h11);
`else
    chk("t4_wb_same_rbusy", 64'(rbusy[0]), 64'd1);
    chk("t4_wb_same_rdata", 64'(rd_port(0)), 64'd0);
`endif
    tick();
    idle();
    rs[0 +: AW] = 5'd4;
    #1;
    chk("t4_wb_cnt", 64'(busy_cnt), 64'd0);
    chk("t4_wb_rbusy", 64'(rbusy[0]), 64'd0);
    chk("t4_wb_rdata", 64'(rd_port(0)), 64'h11);

    // 5a. same register issued and written in one cycle: set wins
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    idle();
    #1;
    chk("t5_pre_cnt", 64'(busy_cnt), 64'd1);
    iss_valid = 1'b1; iss_rd = 5'd9;
    wen = 1'b1; waddr = 5'd9; wdata = 32'h22;
    rs[0 +: AW] = 5'd9;
    #1;
    chk("t5_same_rbusy_now", 64'(rbusy[0]), 64'd1);
    tick();
    idle();
    rs[0 +: AW] = 5'd9;
    #1;
    chk("t5_same_rdata", 64'(rd_port(0)), 64'h22);
    chk("t5_same_rbusy", 64'(rbusy[0]), 64'd1);
    chk("t5_same_cnt", 64'(busy_cnt), 64'd1);

    // 5b. reg10 sets while reg9 clears: net zero
    iss_valid = 1'b1; iss_rd = 5'd10;
    wen = 1'b1; waddr = 5'd9; wdata = 32'h33;
    tick();
    idle();
    rs = {5'd10, 5'd9};
    #1;
    chk("t5_diff_cnt", 64'(busy_cnt), 64'd1);
    chk("t5_diff_rbusy9", 64'(rbusy[0]), 64'd0);
    chk("t5_diff_rbusy10", 64'(rbusy[1]), 64'd1);
    chk("t5_diff_rdata9", 64'(rd_port(0)), 64'h33);

    // re-issue of an already busy register, write to a non-busy register
    iss_valid = 1'b1; iss_rd = 5'd10;
    wen = 1'b1; waddr = 5'd12; wdata = 32'h44;
    tick();
    idle();
    rs[0 +: AW] = 5'd12;
    #1;
    chk("t5_reiss_cnt", 64'(busy_cnt), 64'd1);
    chk("t5_nonbusy_rbusy", 64'(rbusy[0]), 64'd0);
    chk("t5_nonbusy_rdata", 64'(rd_port(0)), 64'h44);

    // count climbs with several in-flight producers
    iss_valid = 1'b1; iss_rd = 5'd1;
    tick();
    iss_rd = 5'd2;
    tick();
    iss_rd = 5'd31;
    tick();
    idle();
    #1;
    chk("t5_multi_cnt", 64'(busy_cnt), 64'd4);
    wen = 1'b1; waddr = 5'd10; wdata = 32'h55;
    tick();
    idle();
    #1;
    chk("t5_retire_cnt", 64'(busy_cnt), 64'd3);

    // 6. same-cycle write and read on reg6 (currently 0)
    wen = 1'b1; waddr = 5'd6; wdata = 32'hCAFEF00D;
    rs[0 +: AW] = 5'd6;
    #1;
`ifdef RF_BYPASS_EN
    chk("t6_same_cycle", 64'(rd_port(0)), 64'hCAFEF00D);
`else
    chk("t6_same_cycle", 64'(rd_port(0)), 64'd0);
`endif
    tick();
    idle();
    rs[0 +: AW] = 5'd6;
    #1;
    chk("t6_next_cycle", 64'(rd_port(0)), 64'hCAFEF00D);
    chk("t6_dbg6", 64'(dbg_reg(6)), 64'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
